// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted through a
// valid/ready handshake and shifted out one bit per en_i tick on a registered
// serial line. After the last data bit, one further tick returns the line to
// IDLE_LEVEL and raises done_o for a single cycle.
//
// Parameters:
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  0: bit 0 leaves first, 1: bit WIDTH-1 leaves first
//   IDLE_LEVEL level on sdata_o while no word is being shifted
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    synchronous reset, active-high, overrides every other input
//   en_i     bit tick; one serial bit advances per cycle with en_i=1
//   data_i   parallel word, sampled only on acceptance
//   valid_i  source presents a word on data_i
//   ready_o  block accepts a word this cycle (IDLE only)
//   sdata_o  registered serial output
//   busy_o   a word is loaded and not yet finished (SHIFT only)
//   done_o   one-cycle pulse when the frame completes
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             sdata_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             head_bit;
  logic             sdata_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  // The register is shifted rather than indexed by the counter: the bit to
  // send next always sits at one end, so no variable-index mux is needed.
  // NOTE: every signal written here gets a value on every path, otherwise a
  // latch is inferred.
  always_comb begin
    head_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    shreg_d  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                         : {1'b0, shreg_q[WIDTH-1:1]};
    cnt_d    = cnt_q + CW'(1);
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the shift register is a plain flop bank, so clearing it in
      // reset is cheap; a frame aborted by reset leaves no stale bits behind.
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sdata_q <= IDLE_LEVEL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Acceptance ignores en_i; the line stays idle until the first tick.
          if (valid_i) begin
            state_q <= SHIFT;
            shreg_q <= data_i;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (en_i) begin
            if (cnt_q == CNT_LAST) begin
              // Closing tick: line back to idle, ready again from this edge.
              state_q <= IDLE;
              sdata_q <= IDLE_LEVEL;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              sdata_q <= head_bit;
              shreg_q <= shreg_d;
              cnt_q   <= cnt_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sdata_o = sdata_q;

endmodule
